axil_reg_slave: RTL and testbench
=================================

// Module: axil_reg_slave
// PURPOSE
//  AXI4-Lite responder (slave) that exposes a bank of 32-bit control/status registers to a bus initiator.
//  It sits at a register window on the PL interconnect (e.g. 0xA001_2000). It completes single-beat
//  writes and reads with OKAY/SLVERR responses, and presents register contents and per-register
//  write strobes to the fabric.
// PARAMETERS
//  ADDR_WIDTH  32            AXI-Lite address width
//  DATA_WIDTH  32            data width; only 32 is supported
//  NUM_REGS    16            number of registers; index = addr[11:2]; power of 2, range 2..1024
//  VERSION     32'h0001_0000 read-only contents of register 0
// PORTS
//  aclk            in   1                     bus clock; all logic is on its rising edge
//  areset          in   1                     asynchronous, active-high reset
//  s_axil_awaddr   in   ADDR_WIDTH            write address
//  s_axil_awprot   in   3                     ignored
//  s_axil_awvalid  in   1                     write address valid
//  s_axil_awready  out  1                     write address ready
//  s_axil_wdata    in   DATA_WIDTH            write data
//  s_axil_wstrb    in   DATA_WIDTH/8          byte enables
//  s_axil_wvalid   in   1                     write data valid
//  s_axil_wready   out  1                     write data ready
//  s_axil_bresp    out  2                     2'b00 OKAY, 2'b10 SLVERR
//  s_axil_bvalid   out  1                     write response valid
//  s_axil_bready   in   1                     write response ready
//  s_axil_araddr   in   ADDR_WIDTH            read address
//  s_axil_arprot   in   3                     ignored
//  s_axil_arvalid  in   1                     read address valid
//  s_axil_arready  out  1                     read address ready
//  s_axil_rdata    out  DATA_WIDTH            read data
//  s_axil_rresp    out  2                     2'b00 OKAY, 2'b10 SLVERR
//  s_axil_rvalid   out  1                     read data valid
//  s_axil_rready   in   1                     read data ready
//  reg_out         out  NUM_REGS*DATA_WIDTH   register contents; reg i is in [i*32 +: 32]
//  reg_wr_stb      out  NUM_REGS              one-cycle pulse on the cycle register i is updated
// BEHAVIOUR
//  Reset (async, areset=1):
//   - All outputs are 0; registers 1..NUM_REGS-1 are 0; both FSMs are IDLE.
//   - Readies go to 1 on the first aclk edge after areset falls.
//   - Reset mid-transaction drops the transaction: no partial write, no response.
//  Write FSM: W_IDLE -> W_RESP -> W_IDLE.
//   - W_IDLE: awready = !aw_held and wready = !w_held.
//   - AW and W are captured independently, in either order or in the same edge.
//   - Each ready drops on the edge after its handshake and stays low until the B handshake completes.
//   - On the edge after both are held: commit the write, assert bvalid, set bresp, move to W_RESP.
//   - W_RESP: bvalid holds until bvalid&bready. On that edge bvalid=0, state returns to W_IDLE,
//     and both readies return to 1. Only one write is outstanding at a time.
//   - Byte lane k is written only where wstrb[k]=1; wstrb=0 gives OKAY with no change, stb still pulses.
//   - reg_wr_stb[i] pulses on the commit edge for OKAY writes only.
//  Read FSM: R_IDLE -> R_DATA -> R_IDLE.
//   - R_IDLE: arready=1. On the AR handshake edge rdata/rresp are registered, rvalid=1 and arready=0.
//     Read latency is 1 cycle.
//   - R_DATA: rdata, rresp and rvalid hold until rvalid&rready; arready returns to 1 on the next edge.
//  Address decode:
//   - idx = addr[11:2]; addr[1:0] and bits above 11 are ignored.
//   - idx >= NUM_REGS: SLVERR; the write is discarded and the read returns 0.
//   - idx = 0: reads return VERSION with OKAY; writes get SLVERR and leave the register unchanged.
//  Simultaneous events:
//   - Read and write FSMs run independently.
//   - Read and commit to the same register on the same edge: the read returns the pre-write value.
// TESTING
//  1. WR 0x A001_2018 = 0xAAAA0777, then RD 0xA001_2018 -> bresp 00, reg_wr_stb[6] pulses once,
//     rdata 0xAAAA0777, rresp 00.
//  2. awvalid 3 cycles before wvalid -> awready low after AW; bvalid only after the W handshake;
//     exactly one write.
//  3. Reg 6 = 0xAAAA0777, write 0x0000_5500 with wstrb 4'b0010 -> reads back 0xAAAA5577.
//  4. WR offset 0x40 (NUM_REGS=16) -> bresp 10, no strobe; RD 0x40 -> rdata 0, rresp 10;
//     WR 0x00 -> bresp 10; RD 0x00 -> 0x0001_0000.
//  5. Hold bready low 5 cycles with a second AW pending -> bvalid held, awready 0,
//     second AW accepted only after B.
//  6. Assert areset after the AW handshake, before W -> outputs 0, registers 0,
//     next WR/RD completes normally.

Source files
------------

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between an initiator and the register responder.
// Handshake rule: a beat transfers on the rising edge where valid and ready are both high; valid never waits on ready.
interface axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: register 0 is a read-only VERSION word, the rest are R/W with byte strobes.
// Single outstanding write and read; independent write and read state machines.
module axil_reg_slave #(
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     DATA_WIDTH = 32,
  parameter int                     NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0]  VERSION    = 32'h0001_0000
) (
  input  logic                           aclk,
  input  logic                           areset,
  axil_reg_slave_if.slave                s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_stb,
  output logic                           dbg_wr_state,
  output logic                           dbg_rd_state
);
  localparam int          STRB_W     = DATA_WIDTH / 8;
  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [10:0] NUM_REGS_L = 11'(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [0:0]             wr_state, rd_state;
  logic                   ready_en;
  logic                   aw_held, w_held;
  logic [ADDR_WIDTH-1:0]  aw_addr_q;
  logic [DATA_WIDTH-1:0]  w_data_q;
  logic [STRB_W-1:0]      w_strb_q;
  logic                   bvalid_q, rvalid_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]  rdata_q, rd_value;
  logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

  // ready_en keeps all readies low until the first edge after reset release
  assign s_axil.awready = ready_en && (wr_state == W_IDLE) && !aw_held;
  assign s_axil.wready  = ready_en && (wr_state == W_IDLE) && !w_held;
  assign s_axil.arready = ready_en && (rd_state == R_IDLE);
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;
  assign dbg_wr_state   = wr_state;
  assign dbg_rd_state   = rd_state;

  logic aw_hs, w_hs, ar_hs, commit;
  assign aw_hs  = s_axil.awvalid && s_axil.awready;
  assign w_hs   = s_axil.wvalid && s_axil.wready;
  assign ar_hs  = s_axil.arvalid && s_axil.arready;
  assign commit = (wr_state == W_IDLE) && aw_held && w_held;

  logic [9:0] wr_idx, rd_idx;
  logic       wr_ok, rd_in_range;
  assign wr_idx      = aw_addr_q[11:2];
  assign rd_idx      = s_axil.araddr[11:2];
  assign wr_ok       = (wr_idx != 10'd0) && ({1'b0, wr_idx} < NUM_REGS_L);
  assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_L;

  logic unused_bits;
  assign unused_bits = ^{s_axil.awprot, s_axil.arprot, aw_addr_q, s_axil.araddr};

  always_comb begin
    rd_value = '0;
    if (rd_in_range) begin
      if (rd_idx == 10'd0) rd_value = VERSION;
      else                 rd_value = regs[rd_idx[IDX_W-1:0]];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state  <= W_IDLE;
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axil.awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axil.wdata;
            w_strb_q <= s_axil.wstrb;
          end
          if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLV;
            wr_state <= W_RESP;
          end
        end
        default: begin
          if (s_axil.bready) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Register storage; a same-edge read sees the pre-write value through non-blocking update
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_stb <= '0;
    end else begin
      reg_wr_stb <= '0;
      if (commit && wr_ok) begin
        reg_wr_stb[wr_idx[IDX_W-1:0]] <= 1'b1;
        for (int k = 0; k < STRB_W; k++) begin
          if (w_strb_q[k]) regs[wr_idx[IDX_W-1:0]][k*8 +: 8] <= w_data_q[k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q  <= rd_value;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLV;
            rvalid_q <= 1'b1;
            rd_state <= R_DATA;
          end
        end
        default: begin
          if (s_axil.rready) begin
            rvalid_q <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    if (g == 0) begin : g_version
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = VERSION;
    end else begin : g_rw
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: drivers push expected B/R responses, a negedge monitor pops and compares.
module tb_axil_reg_slave;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          NR  = 16;
  localparam logic [31:0] VER = 32'h0001_0000;
  localparam int          TMO = 200;

  logic                 aclk = 1'b0;
  logic                 areset = 1'b1;
  logic [NR*DW-1:0]     reg_out;
  logic [NR-1:0]        reg_wr_stb;
  logic                 dbg_wr_state, dbg_rd_state;

  axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .VERSION(VER)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axil       (bus),
    .reg_out      (reg_out),
    .reg_wr_stb   (reg_wr_stb),
    .dbg_wr_state (dbg_wr_state),
    .dbg_rd_state (dbg_rd_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  int          stb_cnt [NR];
  logic [1:0]  b_exp_q [$];
  logic [33:0] r_exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake within %0d cycles", name, TMO);
  endtask

  // scoreboard monitor
  always @(negedge aclk) begin
    if (!areset) begin
      for (int i = 0; i < NR; i++) if (reg_wr_stb[i]) stb_cnt[i]++;
      if (bus.bvalid && bus.bready) begin
        if (b_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got bresp %0d expected no response", bus.bresp);
        end else check("bresp", 64'(bus.bresp), 64'(b_exp_q.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        if (r_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got rdata 0x%0h expected no response", bus.rdata);
        end else check("rresp_rdata", 64'({bus.rresp, bus.rdata}), 64'(r_exp_q.pop_front()));
      end
    end
  end

  // driver tasks: all start and end at posedge+1
  task automatic aw_send(input logic [31:0] addr);
    int n = 0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!bus.awready && n < TMO);
    if (!bus.awready) timeout("aw_handshake");
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!bus.wready && n < TMO);
    if (!bus.wready) timeout("w_handshake");
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr);
    int n = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!bus.arready && n < TMO);
    if (!bus.arready) timeout("ar_handshake");
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && n < TMO) begin
      @(negedge aclk); n++;
    end
    if (b_exp_q.size() != 0 || r_exp_q.size() != 0) begin
      timeout(name);
      b_exp_q.delete(); r_exp_q.delete();
    end
    @(posedge aclk); #1;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input logic [1:0] resp);
    b_exp_q.push_back(resp);
    fork
      aw_send(addr);
      w_send(data, strb);
    join
    wait_done("write_done");
  endtask

  task automatic read(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
    r_exp_q.push_back({resp, data});
    ar_send(addr);
    wait_done("read_done");
  endtask

  function automatic int stb_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += stb_cnt[i];
    return s;
  endfunction

  function automatic int reg_mismatches(input logic [31:0] r6);
    int m = 0;
    for (int i = 0; i < NR; i++) begin
      logic [31:0] e;
      e = (i == 0) ? VER : ((i == 6) ? r6 : 32'h0);
      if (reg_out[i*DW +: DW] !== e) m++;
    end
    return m;
  endfunction

  initial begin
    int n;
    int stb_before;
    for (int i = 0; i < NR; i++) stb_cnt[i] = 0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // reset state
    repeat (2) @(negedge aclk);
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_stb", 64'(reg_wr_stb), 64'd0);
    check("rst_states", 64'({dbg_wr_state, dbg_rd_state}), 64'd0);
    check("rst_reg_out", 64'(reg_mismatches(32'h0)), 64'd0);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("ready_before_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
    @(negedge aclk);
    check("ready_after_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
    @(posedge aclk); #1;

    // 1: basic write/read of reg 6
    write(32'hA001_2018, 32'hAAAA_0777, 4'hF, 2'b00);
    check("t1_stb6", 64'(stb_cnt[6]), 64'd1);
    read(32'hA001_2018, 2'b00, 32'hAAAA_0777);
    check("t1_reg_out6", 64'(reg_out[6*DW +: DW]), 64'hAAAA_0777);

    // 2: AW three cycles ahead of W
    b_exp_q.push_back(2'b00);
    aw_send(32'h0000_0014);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t2_awready_low", 64'(bus.awready), 64'd0);
      check("t2_no_bvalid", 64'(bus.bvalid), 64'd0);
    end
    @(posedge aclk); #1;
    w_send(32'h1234_5678, 4'hF);
    wait_done("t2_done");
    check("t2_stb5", 64'(stb_cnt[5]), 64'd1);
    read(32'h0000_0014, 2'b00, 32'h1234_5678);

    // 3: partial strobe on reg 6
    write(32'h0000_0018, 32'h0000_5500, 4'b0010, 2'b00);
    read(32'h0000_0018, 2'b00, 32'hAAAA_5577);
    check("t3_stb6", 64'(stb_cnt[6]), 64'd2);

    // same-edge read and commit returns the old value
    b_exp_q.push_back(2'b00);
    r_exp_q.push_back({2'b00, 32'hAAAA_5577});
    fork
      aw_send(32'h0000_0018);
      w_send(32'h0BAD_F00D, 4'hF);
    join
    ar_send(32'h0000_0018);
    wait_done("same_edge_done");
    read(32'h0000_0018, 2'b00, 32'h0BAD_F00D);

    // 4: decode errors, VERSION, ignored address bits
    stb_before = stb_total();
    write(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 2'b10);
    read(32'h0000_0040, 2'b10, 32'h0);
    write(32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 2'b10);
    read(32'h0000_0000, 2'b00, 32'h0001_0000);
    check("t4_no_stb", 64'(stb_total()), 64'(stb_before));
    read(32'hA001_301B, 2'b00, 32'h0BAD_F00D);
    write(32'h0000_0010, 32'h0, 4'h0, 2'b00);
    check("t4_zero_strb_stb4", 64'(stb_cnt[4]), 64'd1);
    read(32'h0000_0010, 2'b00, 32'h0);

    // 5: B back-pressure with a second AW pending
    bus.bready = 1'b0;
    b_exp_q.push_back(2'b00);
    fork
      aw_send(32'h0000_001C);
      w_send(32'hCAFE_0007, 4'hF);
    join
    n = 0;
    do begin @(negedge aclk); n++; end while (!bus.bvalid && n < TMO);
    if (!bus.bvalid) timeout("t5_bvalid");
    b_exp_q.push_back(2'b00);
    fork
      aw_send(32'h0000_0020);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge aclk);
          check("t5_bvalid_held", 64'(bus.bvalid), 64'd1);
          check("t5_awready_low", 64'(bus.awready), 64'd0);
        end
        @(posedge aclk); #1 bus.bready = 1'b1;
      end
    join
    w_send(32'h0000_8888, 4'hF);
    wait_done("t5_done");
    check("t5_stb7", 64'(stb_cnt[7]), 64'd1);
    check("t5_stb8", 64'(stb_cnt[8]), 64'd1);
    read(32'h0000_001C, 2'b00, 32'hCAFE_0007);
    read(32'h0000_0020, 2'b00, 32'h0000_8888);

    // 6: reset between AW and W drops the write
    aw_send(32'h0000_0024);
    areset = 1'b1;
    @(negedge aclk);
    check("t6_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
    check("t6_valids", 64'({bus.bvalid, bus.rvalid}), 64'd0);
    check("t6_reg_out", 64'(reg_mismatches(32'h0)), 64'd0);
    @(posedge aclk); #1 areset = 1'b0;
    @(posedge aclk); #1;
    write(32'h0000_0024, 32'h0000_0099, 4'hF, 2'b00);
    read(32'h0000_0024, 2'b00, 32'h0000_0099);
    check("t6_stb9", 64'(stb_cnt[9]), 64'd1);

    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
